// File: rtl/data_convert_pkg.sv
// data_convert_pkg: sizing and lane-mask helpers shared by the unit-packing converter
package data_convert_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lanes(input int out_w, input int unit_w);
    return out_w / unit_w;
  endfunction
  function automatic logic [63:0] lane_mask(input int k);
    return (k >= 64) ? '1 : (64'(1) << k) - 64'(1);
  endfunction
endpackage

// File: rtl/data_convert_lanebuf.sv
// data_convert_lanebuf: 2N-1 lane unit buffer with append, shift-out of N lanes and clear
module data_convert_lanebuf import data_convert_pkg::*; #(
  parameter int N = 2,
  parameter int UNIT_W = 4,
  parameter int LEN_W = 2,
  parameter int CW = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  shift,
  input  logic                  clear,
  input  logic                  app,
  input  logic [LEN_W-1:0]      len,
  input  logic [N*UNIT_W-1:0]   data_in,
  output logic [N*UNIT_W-1:0]   head,
  output logic [CW-1:0]         cnt
);
  localparam int LW = 2*N-1;
  localparam int BW = LW*UNIT_W;
  logic [BW-1:0] q, q_s, ins, m;
  logic [CW-1:0] cnt_s;
  logic [LW-1:0] lm;
  assign head = q[N*UNIT_W-1:0];
  always_comb begin
    cnt_s = shift ? cnt - CW'(N) : clear ? '0 : cnt;
    q_s = shift ? q >> (N*UNIT_W) : q;
    ins = BW'(data_in) << (cnt_s * UNIT_W);
    lm = app ? LW'(lane_mask(int'(len)) << cnt_s) : '0;
    m = '0;
    for (int i = 0; i < LW; i++) m[i*UNIT_W +: UNIT_W] = {UNIT_W{lm[i]}};
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      q <= '0;
      cnt <= '0;
    end else begin
      q <= (q_s & ~m) | (ins & m);
      cnt <= cnt_s + (app ? CW'(len) : '0);
    end
endmodule

// File: rtl/data_convert_pack.sv
// data_convert_pack: packs 1..N narrow units per beat LSB-first into OUT_W words with valid/ready and flush
module data_convert_pack import data_convert_pkg::*; #(
  parameter int OUT_W = 8,
  parameter int UNIT_W = 4,
  localparam int N = lanes(OUT_W, UNIT_W),
  localparam int LEN_W = clog2(N+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [OUT_W-1:0] data_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             in_ready,
  output logic [OUT_W-1:0] data_o,
  output logic             data_en,
  output logic [LEN_W-1:0] data_cnt,
  output logic             err
);
  localparam int CW = clog2(2*N);
  logic [CW-1:0] cnt;
  logic [OUT_W-1:0] head, pm;
  logic flush_pend, out_free, full, part, drop, legal, acc;
  always_comb begin
    out_free = !data_en || out_ready;
    full = out_free && cnt >= CW'(N);
    part = out_free && flush_pend && !full && cnt != '0;
    drop = out_free && flush_pend && cnt == '0;
    in_ready = reset_n && !flush_pend && ((full ? cnt - CW'(N) : cnt) < CW'(N));
    legal = len != '0 && len <= LEN_W'(N);
    acc = start && in_ready;
    pm = '0;
    for (int i = 0; i < N; i++) pm[i*UNIT_W +: UNIT_W] = {UNIT_W{CW'(i) < cnt}};
  end
  data_convert_lanebuf #(.N(N), .UNIT_W(UNIT_W), .LEN_W(LEN_W), .CW(CW)) u_buf (
    .clk(clk),
    .reset_n(reset_n),
    .shift(full),
    .clear(part),
    .app(acc && legal),
    .len(len),
    .data_in(data_in),
    .head(head),
    .cnt(cnt)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      data_o <= '0;
      data_en <= 1'b0;
      data_cnt <= '0;
      err <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (full || part) begin
        data_o <= full ? head : head & pm;
        data_cnt <= full ? LEN_W'(N) : LEN_W'(cnt);
        data_en <= 1'b1;
      end else if (out_ready) data_en <= 1'b0;
      err <= acc && !legal;
      flush_pend <= flush || (flush_pend && !part && !drop);
    end
endmodule

// File: tb/tb_data_convert_pack.sv
// tb_data_convert_pack: vector table plus unit-queue scoreboard for data_convert_pack
module tb_data_convert_pack;
  localparam int N = 2;
  typedef struct { logic [7:0] d; logic [1:0] c; } word_t;
  typedef struct { logic st; int ln; logic [7:0] d; logic fl; logic ordy; logic rdy; logic er; } vec_t;
  logic clk = 1'b0;
  logic reset_n, start, flush, out_ready, in_ready, data_en, err;
  logic [1:0] len, data_cnt;
  logic [7:0] data_in, data_o;
  int total = 0;
  int passed = 0;
  word_t exp_q[$];
  int mq[$];
  vec_t tbl[$];
  word_t w;
  always #5 clk = ~clk;
  data_convert_pack #(.OUT_W(8), .UNIT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .data_in(data_in),
    .flush(flush), .out_ready(out_ready), .in_ready(in_ready), .data_o(data_o),
    .data_en(data_en), .data_cnt(data_cnt), .err(err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else passed++;
  endtask
  function automatic vec_t mk(input logic st, input int ln, input logic [7:0] d, input logic fl,
                              input logic ordy, input logic rdy, input logic er);
    vec_t v;
    v.st = st; v.ln = ln; v.d = d; v.fl = fl; v.ordy = ordy; v.rdy = rdy; v.er = er;
    return v;
  endfunction
  task automatic model(input vec_t v);
    word_t x;
    if (v.st && v.rdy && v.ln >= 1 && v.ln <= N)
      for (int i = 0; i < v.ln; i++) mq.push_back(int'(v.d[i*4 +: 4]));
    while (mq.size() >= N) begin
      x.d = {4'(mq[1]), 4'(mq[0])};
      x.c = 2'd2;
      void'(mq.pop_front());
      void'(mq.pop_front());
      exp_q.push_back(x);
    end
    if (v.fl && mq.size() > 0) begin
      x.d = {4'h0, 4'(mq[0])};
      x.c = 2'd1;
      mq.delete();
      exp_q.push_back(x);
    end
  endtask
  task automatic step(input vec_t v);
    start = v.st;
    len = v.ln[1:0];
    data_in = v.d;
    flush = v.fl;
    out_ready = v.ordy;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, v.rdy});
    model(v);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (reset_n === 1'b1 && data_en && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_extra: unexpected word %0h", data_o);
      end else begin
        w = exp_q.pop_front();
        chk("sb_data", {24'b0, data_o}, {24'b0, w.d});
        chk("sb_cnt", {30'b0, data_cnt}, {30'b0, w.c});
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl.push_back(mk(1, 1, 8'h04, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 8'h01, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(1, 2, 8'h69, 0, 1, 1, 0));
    tbl.push_back(mk(1, 2, 8'h21, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 8'h05, 0, 1, 1, 0));
    tbl.push_back(mk(1, 2, 8'hA5, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(1, 2, 8'h11, 0, 0, 1, 0));
    tbl.push_back(mk(1, 2, 8'h22, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'hFF, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(1, 3, 8'hFF, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 8'h0C, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 8'h0D, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    reset_n = 1'b0;
    start = 1'b0;
    len = '0;
    data_in = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_o", {24'b0, data_o}, 32'h0);
    chk("rst_data_en", {31'b0, data_en}, 32'h0);
    chk("rst_data_cnt", {30'b0, data_cnt}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    reset_n = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k]);
      chk("err", {31'b0, err}, {31'b0, tbl[k].er});
    end
    step(mk(1, 1, 8'h04, 0, 1, 1, 0));
    step(mk(1, 1, 8'h01, 0, 1, 1, 0));
    chk("t1_not_yet", {31'b0, data_en}, 32'h0);
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    chk("t1_en", {31'b0, data_en}, 32'h1);
    chk("t1_data", {24'b0, data_o}, 32'h14);
    chk("t1_cnt", {30'b0, data_cnt}, 32'h2);
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    chk("t1_en_drop", {31'b0, data_en}, 32'h0);
    step(mk(1, 2, 8'h69, 0, 1, 1, 0));
    step(mk(1, 2, 8'h21, 0, 1, 1, 0));
    chk("t2_first", {24'b0, data_o}, 32'h69);
    chk("t2_first_en", {31'b0, data_en}, 32'h1);
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    chk("t2_second", {24'b0, data_o}, 32'h21);
    chk("t2_second_en", {31'b0, data_en}, 32'h1);
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    step(mk(1, 1, 8'h05, 0, 1, 1, 0));
    step(mk(1, 2, 8'hA5, 0, 1, 1, 0));
    step(mk(0, 0, 8'h00, 1, 1, 1, 0));
    chk("t3_full", {24'b0, data_o}, 32'h55);
    chk("t3_full_cnt", {30'b0, data_cnt}, 32'h2);
    step(mk(0, 0, 8'h00, 0, 1, 0, 0));
    chk("t3_part", {24'b0, data_o}, 32'h0A);
    chk("t3_part_cnt", {30'b0, data_cnt}, 32'h1);
    chk("t3_part_en", {31'b0, data_en}, 32'h1);
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    step(mk(1, 1, 8'h07, 0, 1, 1, 0));
    reset_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("t6_rdy_in_rst", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("t6_data_o", {24'b0, data_o}, 32'h0);
    chk("t6_data_en", {31'b0, data_en}, 32'h0);
    chk("t6_data_cnt", {30'b0, data_cnt}, 32'h0);
    chk("t6_err", {31'b0, err}, 32'h0);
    chk("t6_sb_empty", exp_q.size(), 32'h0);
    mq.delete();
    exp_q.delete();
    reset_n = 1'b1;
    step(mk(1, 1, 8'h03, 0, 1, 1, 0));
    step(mk(1, 1, 8'h09, 0, 1, 1, 0));
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    chk("t6_word", {24'b0, data_o}, 32'h93);
    chk("t6_cnt", {30'b0, data_cnt}, 32'h2);
    chk("t6_en", {31'b0, data_en}, 32'h1);
    step(mk(0, 0, 8'h00, 0, 1, 1, 0));
    chk("sb_drain", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
